aes_round_engine: RTL and testbench

AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

---
 rtl/aes_round_engine.sv | 135 +++++++++++++
 tb/tb_aes_round_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encryptor, one round per clock, round keys from an external schedule
module aes_sub_bytes (
  input  logic [127:0] d_i,
  output logic [127:0] d_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // Inverse as x^254 via a fixed square-and-multiply chain, then the AES affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, v;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    v    = gmul(x252, x2);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign d_o[8*i +: 8] = sbox(d_i[8*i +: 8]);
  end
endmodule

module aes_shift_rows (
  input  logic [127:0] d_i,
  output logic [127:0] d_o
);
  for (genvar i = 0; i < 16; i++) begin : g_sr
    assign d_o[127-8*i -: 8] = d_i[127-8*(4*((i/4 + i%4) % 4) + i%4) -: 8];
  end
endmodule

module aes_mix_columns (
  input  logic [127:0] d_i,
  output logic [127:0] d_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign d_o[127-32*c -: 32] = col(d_i[127-32*c -: 32]);
  end
endmodule

module aes_add_round_key (
  input  logic [127:0] a_i,
  input  logic [127:0] k_i,
  output logic [127:0] d_o
);
  assign d_o = a_i ^ k_i;
endmodule

module aes_round_engine #(
  parameter int KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [31:0]  blk_count
);
  localparam logic [3:0] NR = KEY_BITS == 128 ? 4'd10 : KEY_BITS == 192 ? 4'd12 :
                              KEY_BITS == 256 ? 4'd14 : 4'd0;
  if (NR == 4'd0) begin : g_bad_key_bits
    $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
  end
  localparam logic [1:0] IDLE = 2'd0, ROUND = 2'd1, HOLD = 2'd2;
  logic [1:0]   fsm_q, fsm_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] state_q, state_d, sb, sr, mc, ark_a, ark;
  logic [31:0]  blk_count_q, blk_count_d;
  logic         accept, last, hs;
  assign busy      = fsm_q == ROUND;
  assign out_valid = fsm_q == HOLD;
  assign hs        = out_valid && out_ready;
  assign in_ready  = !rst && (fsm_q == IDLE || hs);
  assign accept    = in_valid && in_ready;
  assign last      = r_q == NR;
  assign rk_idx    = busy ? r_q : 4'd0;
  assign out_data  = state_q;
  assign blk_count = blk_count_q;
  aes_sub_bytes     u_sb  (.d_i(state_q), .d_o(sb));
  aes_shift_rows    u_sr  (.d_i(sb), .d_o(sr));
  aes_mix_columns   u_mc  (.d_i(sr), .d_o(mc));
  // The single AddRoundKey serves both the round-0 whitening on accept and every later round
  assign ark_a = accept ? in_data : last ? sr : mc;
  aes_add_round_key u_ark (.a_i(ark_a), .k_i(rk), .d_o(ark));
  always_comb begin
    fsm_d       = accept ? ROUND : busy ? (last ? HOLD : ROUND) : hs ? IDLE : fsm_q;
    r_d         = accept ? 4'd1 : busy ? (last ? 4'd0 : r_q + 4'd1) : r_q;
    state_d     = (accept || busy) ? ark : state_q;
    blk_count_d = blk_count_q + {31'd0, hs};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q       <= IDLE;
      r_q         <= 4'd0;
      state_q     <= 128'd0;
      blk_count_q <= 32'd0;
    end else begin
      fsm_q       <= fsm_d;
      r_q         <= r_d;
      state_q     <= state_d;
      blk_count_q <= blk_count_d;
    end
  end
endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: FIPS-197 vectors on all three key sizes, plus stall, streaming, reset and wrap cases
module tb_aes_round_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic         v[3], ir[3], ov[3], rdy[3], bsy[3];
  logic [127:0] din[3], od[3], rkv[3];
  logic [3:0]   idx[3];
  logic [31:0]  bc[3];
  logic [127:0] rks[3][15];
  logic [127:0] ct[3];
  logic [127:0] pt;
  int checks = 0, errors = 0;
  typedef struct { int g; logic [127:0] d; } exp_t;
  exp_t sbq[$];

  for (genvar g = 0; g < 3; g++) begin : u
    aes_round_engine #(.KEY_BITS(128 + 64*g)) dut (
      .clk(clk), .rst(rst), .in_valid(v[g]), .in_ready(ir[g]), .in_data(din[g]),
      .rk_idx(idx[g]), .rk(rkv[g]), .out_valid(ov[g]), .out_ready(rdy[g]),
      .out_data(od[g]), .busy(bsy[g]), .blk_count(bc[g]));
    assign rkv[g] = rks[g][idx[g]];
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference S-box: inverse found by exhaustive search rather than by exponentiation
  function automatic logic [7:0] sbr(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int c = 1; c < 256; c++) if (gm(x, 8'(c)) == 8'h01) y = 8'(c);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbr(w[31:24]), sbr(w[23:16]), sbr(w[15:8]), sbr(w[7:0])};
  endfunction

  function automatic void expand(input int gi);
    logic [31:0]  w[60];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [255:0] key;
    int nk;
    nk  = 4 + 2*gi;
    key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    rc  = 8'h01;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) t = subw(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int j = 0; j < 15; j++) rks[gi][j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst && ov[k] && rdy[k]) begin
        checks++;
        assert (sbq.size() > 0) else begin
          errors++;
          $error("FAIL sb_extra: observed dut%0d output %h expected none", k, od[k]);
        end
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_dut", k, e.g);
          chk("sb_data", od[k], e.d);
        end
      end
    end
  end

  task automatic send(input int g, input logic [127:0] p, input logic [127:0] e, input bit push);
    chk("ready_pre", ir[g], 1);
    v[g] = 1'b1;
    din[g] = p;
    if (push) sbq.push_back('{g, e});
    @(posedge clk); #1;
    v[g] = 1'b0;
  endtask

  task automatic wait_out(input int g, input int nr, input string tag);
    int n;
    n = 0;
    while (!ov[g] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, n, nr);
  endtask

  initial begin
    int acc, cyc, lastc, n;
    logic a;
    logic [31:0] bcs;
    pt = 128'h00112233445566778899aabbccddeeff;
    ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0;
      rdy[k] = 1'b1;
      din[k] = '0;
      expand(k);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ir[0], 0);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_rk_idx", idx[0], 0);
    chk("rst_blk_count", bc[0], 0);
    chk("rst_state", od[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ir[0], 1);
    send(0, pt, ct[0], 1);
    chk("busy_round1", bsy[0], 1);
    chk("rk_idx_round1", idx[0], 1);
    chk("in_ready_round", ir[0], 0);
    wait_out(0, 10, "lat128");
    @(posedge clk); #1;
    chk("idle_after_hs", ov[0], 0);
    chk("count_one", bc[0], 1);
    send(1, pt, ct[1], 1);
    wait_out(1, 12, "lat192");
    @(posedge clk); #1;
    send(2, pt, ct[2], 1);
    wait_out(2, 14, "lat256");
    @(posedge clk); #1;
    chk("count256", bc[2], 1);
    // Stall: consumer not ready for 20 cycles while a new block is offered
    rdy[0] = 1'b0;
    send(0, pt, ct[0], 1);
    wait_out(0, 10, "lat_stall");
    bcs = bc[0];
    v[0] = 1'b1;
    din[0] = ~pt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", ov[0], 1);
      chk("stall_data", od[0], ct[0]);
      chk("stall_in_ready", ir[0], 0);
      chk("stall_count", bc[0], bcs);
    end
    v[0] = 1'b0;
    rdy[0] = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_valid", ov[0], 0);
    chk("stall_release_count", bc[0], bcs + 1);
    // Asynchronous reset in the middle of round 5 drops the block
    send(0, pt, ct[0], 0);
    repeat (4) @(posedge clk);
    #1;
    chk("rk_idx_r5", idx[0], 5);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bsy[0], 0);
    chk("arst_rk_idx", idx[0], 0);
    chk("arst_in_ready", ir[0], 0);
    chk("arst_count", bc[0], 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("arst_no_out", ov[0], 0);
    end
    chk("arst_count_after", bc[0], 0);
    // Back-to-back streaming of four blocks
    v[0] = 1'b1;
    din[0] = pt;
    acc = 0;
    cyc = 0;
    lastc = 0;
    while (acc < 4 && cyc < 100) begin
      @(negedge clk);
      a = ir[0];
      @(posedge clk); #1;
      if (a) begin
        sbq.push_back('{0, ct[0]});
        if (acc > 0) chk("stream_gap", cyc - lastc, 11);
        lastc = cyc;
        acc++;
        if (acc == 4) v[0] = 1'b0;
      end
      cyc++;
    end
    v[0] = 1'b0;
    chk("stream_accepts", acc, 4);
    n = 0;
    while (bc[0] != 32'd4 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stream_count", bc[0], 4);
    // Counter wrap
    @(negedge clk);
    force u[0].dut.blk_count_q = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release u[0].dut.blk_count_q;
    chk("wrap_preload", bc[0], 32'hFFFFFFFF);
    send(0, pt, ct[0], 1);
    wait_out(0, 10, "lat_wrap");
    @(posedge clk); #1;
    chk("wrap_count", bc[0], 0);
    chk("sb_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
